vga_fill_master: RTL and testbench

VGA_FILL_MASTER -- requirements
Module: vga_fill_master

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_bus_wr_port.sv | 35 +++
 rtl/vga_fill_master.sv | 145 ++++++++++++++
 tb/tb_vga_fill_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared register offsets, screen defaults and fill FSM encoding
package vga_pkg;

    localparam int VGA_X_MAX = 160;
    localparam int VGA_Y_MAX = 120;

    localparam logic [7:0] REG_X    = 8'd0;
    localparam logic [7:0] REG_Y    = 8'd1;
    localparam logic [7:0] REG_DATA = 8'd2;
    localparam logic [7:0] REG_WE   = 8'd3;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        WR_DATA,
        WR_X,
        WR_Y,
        WE_HI,
        WE_LO,
        ADV,
        FIN
    } fill_state_t;

endpackage

// File: rtl/vga_bus_wr_port.sv
// rtl/vga_bus_wr_port.sv - registered bus write port with grant gating and tristate data
module vga_bus_wr_port (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       BUS_GNT,
    input  logic       ld_we,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic [7:0] BUS_ADDR,
    output logic       BUS_WE,
    inout  wire  [7:0] BUS_DATA
);

    logic       we_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            we_q   <= 1'b0;
            addr_q <= 8'h00;
            data_q <= 8'h00;
        end else begin
            we_q   <= ld_we;
            addr_q <= ld_addr;
            data_q <= ld_data;
        end
    end

    // Losing the grant releases the bus in the same cycle; the registers keep the pending write.
    assign BUS_WE   = we_q & BUS_GNT;
    assign BUS_ADDR = BUS_WE ? addr_q : 8'h00;
    assign BUS_DATA = BUS_WE ? data_q : 8'hzz;

endmodule

// File: rtl/vga_fill_master.sv
// rtl/vga_fill_master.sv - rectangle fill bus master for the VGA pixel registers (optional FILL_CLIP_EN)
import vga_pkg::*;

module vga_fill_master #(
    parameter logic [7:0] BASE_ADDR = 8'hB0,
    parameter int         X_MAX     = VGA_X_MAX,
    parameter int         Y_MAX     = VGA_Y_MAX
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       START,
    input  logic [7:0] X0,
    input  logic [6:0] Y0,
    input  logic [7:0] W,
    input  logic [6:0] H,
    input  logic       COLOUR,
    output logic       BUSY,
    output logic       DONE,
    output logic       BUS_REQ,
    input  logic       BUS_GNT,
    output logic [7:0] BUS_ADDR,
    output logic       BUS_WE,
    inout  wire  [7:0] BUS_DATA
);

`ifdef FILL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam logic [8:0] X_LIM = 9'(X_MAX);
    localparam logic [7:0] Y_LIM = 8'(Y_MAX);

    fill_state_t state, next_state;
    logic [8:0]  cur_x, nxt_x, x0_q, x_end, adv_x;
    logic [7:0]  cur_y, nxt_y, y0_q, y_end, adv_y;
    logic [7:0]  w_q;
    logic [6:0]  h_q;
    logic        colour_q;
    logic        row_end, last_pix, adv_vis, off_screen;
    logic        ld_we;
    logic [7:0]  ld_addr, ld_data;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            cur_x    <= 9'd0;
            cur_y    <= 8'd0;
            x0_q     <= 9'd0;
            y0_q     <= 8'd0;
            w_q      <= 8'd0;
            h_q      <= 7'd0;
            colour_q <= 1'b0;
        end else begin
            state <= next_state;
            cur_x <= nxt_x;
            cur_y <= nxt_y;
            if (state == IDLE && START) begin
                x0_q     <= {1'b0, X0};
                y0_q     <= {1'b0, Y0};
                w_q      <= W;
                h_q      <= H;
                colour_q <= COLOUR;
            end
        end
    end

    // Counters are one bit wider than the inputs so X0+W and Y0+H never wrap.
    assign x_end    = x0_q + {1'b0, w_q};
    assign y_end    = y0_q + {1'b0, h_q};
    assign row_end  = (cur_x + 9'd1) == x_end;
    assign last_pix = row_end && ((cur_y + 8'd1) == y_end);
    assign adv_x    = row_end ? x0_q : cur_x + 9'd1;
    assign adv_y    = row_end ? cur_y + 8'd1 : cur_y;
    assign adv_vis  = !CLIP_EN || ((adv_x < X_LIM) && (adv_y < Y_LIM));
    assign off_screen = CLIP_EN && (({1'b0, X0} >= X_LIM) || ({1'b0, Y0} >= Y_LIM));

    always_comb begin
        next_state = state;
        nxt_x      = cur_x;
        nxt_y      = cur_y;
        case (state)
            IDLE: begin
                if (START) begin
                    nxt_x = {1'b0, X0};
                    nxt_y = {1'b0, Y0};
                    if (W == 8'd0 || H == 7'd0 || off_screen)
                        next_state = FIN;
                    else
                        next_state = REQ;
                end
            end
            REQ:     if (BUS_GNT) next_state = WR_DATA;
            WR_DATA: if (BUS_GNT) next_state = WR_X;
            WR_X:    if (BUS_GNT) next_state = WR_Y;
            WR_Y:    if (BUS_GNT) next_state = WE_HI;
            WE_HI:   if (BUS_GNT) next_state = WE_LO;
            WE_LO:   if (BUS_GNT) next_state = ADV;
            ADV: begin
                if (last_pix) begin
                    next_state = FIN;
                end else begin
                    nxt_x      = adv_x;
                    nxt_y      = adv_y;
                    next_state = adv_vis ? WR_X : ADV;
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus registers are loaded from the state being entered so each write shows during its own state.
    always_comb begin
        ld_we   = 1'b0;
        ld_addr = 8'h00;
        ld_data = 8'h00;
        case (next_state)
            WR_DATA: begin ld_we = 1'b1; ld_addr = BASE_ADDR + REG_DATA; ld_data = {7'b0, colour_q}; end
            WR_X:    begin ld_we = 1'b1; ld_addr = BASE_ADDR + REG_X;    ld_data = nxt_x[7:0]; end
            WR_Y:    begin ld_we = 1'b1; ld_addr = BASE_ADDR + REG_Y;    ld_data = {1'b0, nxt_y[6:0]}; end
            WE_HI:   begin ld_we = 1'b1; ld_addr = BASE_ADDR + REG_WE;   ld_data = 8'h01; end
            WE_LO:   begin ld_we = 1'b1; ld_addr = BASE_ADDR + REG_WE;   ld_data = 8'h00; end
            default: ;
        endcase
    end

    assign BUSY    = state != IDLE;
    assign DONE    = state == FIN;
    assign BUS_REQ = state != IDLE && state != FIN;

    vga_bus_wr_port u_wr_port (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .BUS_GNT  (BUS_GNT),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .BUS_ADDR (BUS_ADDR),
        .BUS_WE   (BUS_WE),
        .BUS_DATA (BUS_DATA)
    );

endmodule

// File: tb/tb_vga_fill_master.sv
// tb/tb_vga_fill_master.sv - directed-vector bench for vga_fill_master
module tb_vga_fill_master;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic       colour;
    logic       busy;
    logic       done;
    logic       bus_req;
    logic       bus_gnt;
    logic [7:0] bus_addr;
    logic       bus_we;
    wire  [7:0] bus_data;

    int n_vec;
    int n_bad;
    int done_cnt;
    int wr_at_done;
    int cyc;
    int seen;
    logic [15:0] wlog[$];
    logic [15:0] exp_q[$];

    localparam logic [15:0] FILL_TBL [17] = '{
        16'hB201,
        16'hB00A, 16'hB105, 16'hB301, 16'hB300,
        16'hB00B, 16'hB105, 16'hB301, 16'hB300,
        16'hB00A, 16'hB106, 16'hB301, 16'hB300,
        16'hB00B, 16'hB106, 16'hB301, 16'hB300
    };

`ifdef FILL_CLIP_EN
    localparam logic [15:0] EDGE_TBL [9] = '{
        16'hB201,
        16'hB09E, 16'hB100, 16'hB301, 16'hB300,
        16'hB09F, 16'hB100, 16'hB301, 16'hB300
    };
`else
    localparam logic [15:0] EDGE_TBL [9] = '{
        16'hB200,
        16'hB0FF, 16'hB17F, 16'hB301, 16'hB300,
        16'hB000, 16'hB17F, 16'hB301, 16'hB300
    };
`endif

    vga_fill_master dut (
        .CLK      (clk),
        .RESET_N  (rst_n),
        .START    (start),
        .X0       (x0),
        .Y0       (y0),
        .W        (w),
        .H        (h),
        .COLOUR   (colour),
        .BUSY     (busy),
        .DONE     (done),
        .BUS_REQ  (bus_req),
        .BUS_GNT  (bus_gnt),
        .BUS_ADDR (bus_addr),
        .BUS_WE   (bus_we),
        .BUS_DATA (bus_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus_we) wlog.push_back({bus_addr, bus_data});
        if (done) begin
            done_cnt++;
            wr_at_done = wlog.size();
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cmp_log(input string tag);
        chk_eq({tag, "_len"}, wlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk_eq($sformatf("%s_w%0d", tag, i),
                   (i < wlog.size()) ? {16'h0, wlog[i]} : 32'hFFFF_FFFF, {16'h0, exp_q[i]});
    endtask

    task automatic load_fill_tbl();
        exp_q.delete();
        for (int i = 0; i < 17; i++) exp_q.push_back(FILL_TBL[i]);
    endtask

    task automatic clear_log();
        wlog.delete();
        done_cnt   = 0;
        wr_at_done = -1;
    endtask

    task automatic start_fill(input logic [7:0] sx, input logic [6:0] sy,
                              input logic [7:0] sw, input logic [6:0] sh, input logic sc);
        @(posedge clk);
        #1;
        x0 = sx; y0 = sy; w = sw; h = sh; colour = sc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        bit got;
        got    = 1'b0;
        cycles = budget;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got    = 1'b1;
                cycles = i;
                break;
            end
        end
        chk_eq({tag, "_done"}, got, 1);
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; bus_gnt = 1'b1;
        x0 = 0; y0 = 0; w = 0; h = 0; colour = 0;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_req", bus_req, 0);
        chk_eq("rst_we", bus_we, 0);
        chk_eq("rst_addr", bus_addr, 8'h00);
        chk_eq("rst_data_z", bus_data === 8'hzz, 1);
        rst_n = 1'b1;

        // basic 2x2 fill
        clear_log();
        start_fill(8'd10, 7'd5, 8'd2, 7'd2, 1'b1);
        chk_eq("fill_busy", busy, 1);
        chk_eq("fill_req", bus_req, 1);
        wait_done("fill", 200, cyc);
        repeat (5) @(negedge clk);
        load_fill_tbl();
        cmp_log("fill");
        chk_eq("fill_wr_at_done", wr_at_done, 17);
        chk_eq("fill_done_cnt", done_cnt, 1);
        chk_eq("fill_idle_busy", busy, 0);

        // zero width
        clear_log();
        start_fill(8'd10, 7'd5, 8'd0, 7'd3, 1'b1);
        wait_done("w0", 10, cyc);
        chk_eq("w0_latency", cyc <= 1, 1);
        repeat (5) @(negedge clk);
        chk_eq("w0_writes", wlog.size(), 0);

        // grant drop during WE_HI of pixel 2
        clear_log();
        start_fill(8'd10, 7'd5, 8'd2, 7'd2, 1'b1);
        seen = 0;
        for (int i = 0; i < 100 && seen < 2; i++) begin
            @(negedge clk);
            if (bus_we && bus_addr == 8'hB1) seen++;
        end
        chk_eq("gnt_found", seen, 2);
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq($sformatf("gnt_we_%0d", i), bus_we, 0);
            chk_eq($sformatf("gnt_addr_%0d", i), bus_addr, 8'h00);
            chk_eq($sformatf("gnt_z_%0d", i), bus_data === 8'hzz, 1);
        end
        @(posedge clk);
        #1;
        bus_gnt = 1'b1;
        wait_done("gnt", 200, cyc);
        repeat (3) @(negedge clk);
        load_fill_tbl();
        cmp_log("gnt");

        // reset mid-fill, then fill again from scratch
        clear_log();
        start_fill(8'd10, 7'd5, 8'd2, 7'd2, 1'b1);
        repeat (4) @(negedge clk);
        chk_eq("mid_we_before", bus_we, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("mid_busy", busy, 0);
        chk_eq("mid_done", done, 0);
        chk_eq("mid_req", bus_req, 0);
        chk_eq("mid_we", bus_we, 0);
        chk_eq("mid_addr", bus_addr, 8'h00);
        chk_eq("mid_data_z", bus_data === 8'hzz, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        repeat (5) @(negedge clk);
        chk_eq("mid_no_resume", wlog.size(), 0);
        chk_eq("mid_idle", busy, 0);
        start_fill(8'd10, 7'd5, 8'd2, 7'd2, 1'b1);
        wait_done("refill", 200, cyc);
        repeat (3) @(negedge clk);
        load_fill_tbl();
        cmp_log("refill");

        // second START while busy
        clear_log();
        start_fill(8'd10, 7'd5, 8'd2, 7'd2, 1'b1);
        repeat (3) @(negedge clk);
        start_fill(8'd50, 7'd20, 8'd1, 7'd1, 1'b0);
        wait_done("dbl", 200, cyc);
        repeat (20) @(negedge clk);
        load_fill_tbl();
        cmp_log("dbl");
        chk_eq("dbl_done_cnt", done_cnt, 1);

        // right/bottom edge: clipped in the clip build, wrapped otherwise
        clear_log();
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(EDGE_TBL[i]);
`ifdef FILL_CLIP_EN
        start_fill(8'd158, 7'd0, 8'd4, 7'd1, 1'b1);
`else
        start_fill(8'd255, 7'd127, 8'd2, 7'd1, 1'b0);
`endif
        wait_done("edge", 200, cyc);
        repeat (3) @(negedge clk);
        cmp_log("edge");
        chk_eq("edge_done_cnt", done_cnt, 1);

`ifdef FILL_CLIP_EN
        clear_log();
        start_fill(8'd200, 7'd10, 8'd4, 7'd2, 1'b1);
        wait_done("offscr", 10, cyc);
        chk_eq("offscr_latency", cyc <= 1, 1);
        repeat (5) @(negedge clk);
        chk_eq("offscr_writes", wlog.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
